// File: rtl/spi_apb_feeder.sv
// spi_apb_feeder: APB master that drains a local byte FIFO into the SPI TXDATA register and
// pulls RXDATA into a valid/ready stream. Define SPI_FEEDER_RX_EN to build the RX path.
module spi_apb_feeder #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 64
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              TxValid,
  input  logic [7:0]        TxByte,
  output logic              TxReady,
  input  logic              RxEn,
  output logic              RxValid,
  output logic [7:0]        RxByte,
  input  logic              RxReady,
  output logic              Busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [7:0]        PADDR,
  output logic [XLEN-1:0]   PWDATA,
  output logic [XLEN/8-1:0] PSTRB,
  input  logic              PREADY,
  input  logic [XLEN-1:0]   PRDATA
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL    = (AW+1)'(DEPTH);
  localparam logic [7:0]  ADDR_TXDATA = 8'h48;
  localparam logic [7:0]  ADDR_RXDATA = 8'h4C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TXP_S,
    S_TXP_A,
    S_TXW_S,
    S_TXW_A
`ifdef SPI_FEEDER_RX_EN
    , S_RXR_S,
    S_RXR_A
`endif
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;
  logic          w_tx_req;

  assign TxReady  = (r_count < CNT_FULL);
  assign w_push   = TxValid & TxReady;
  assign w_pop    = (r_state == S_TXW_A) & PREADY;
  assign w_tx_req = (r_count != '0);
  assign Busy     = w_tx_req | (r_state != S_IDLE);

  // NOTE: every clocked process uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the byte store has no reset; an entry is only read after it has been written.
  always_ff @(posedge PCLK) begin
    if (w_push) r_mem[r_wr_ptr] <= TxByte;
  end

`ifdef SPI_FEEDER_RX_EN
  logic       r_last_grant_rx;
  logic       r_rx_valid;
  logic [7:0] r_rx_byte;
  logic       w_rx_req;
  logic       w_unused;

  assign w_rx_req = RxEn & ~r_rx_valid;
  assign RxValid  = r_rx_valid;
  assign RxByte   = r_rx_byte;
  assign w_unused = ^PRDATA;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_last_grant_rx <= 1'b0;
      r_rx_valid      <= 1'b0;
      r_rx_byte       <= '0;
    end else begin
      if (r_state == S_IDLE && w_next_state != S_IDLE)
        r_last_grant_rx <= (w_next_state == S_RXR_S);
      // Bit 31 of RXDATA flags an empty receive FIFO; nothing to capture then.
      if (r_state == S_RXR_A && PREADY && !PRDATA[31]) begin
        r_rx_valid <= 1'b1;
        r_rx_byte  <= PRDATA[7:0];
      end else if (r_rx_valid && RxReady) begin
        r_rx_valid <= 1'b0;
      end
    end
  end
`else
  logic w_unused;

  assign RxValid  = 1'b0;
  assign RxByte   = '0;
  assign w_unused = ^{RxEn, RxReady, PRDATA};
`endif

  always_comb begin
    w_next_state = r_state;
    PSEL         = 1'b0;
    PENABLE      = 1'b0;
    PWRITE       = 1'b0;
    PADDR        = '0;
    PWDATA       = '0;
    PSTRB        = '0;
    case (r_state)
      S_IDLE: begin
`ifdef SPI_FEEDER_RX_EN
        if (w_tx_req && w_rx_req) w_next_state = r_last_grant_rx ? S_TXP_S : S_RXR_S;
        else if (w_tx_req)        w_next_state = S_TXP_S;
        else if (w_rx_req)        w_next_state = S_RXR_S;
`else
        if (w_tx_req) w_next_state = S_TXP_S;
`endif
      end
      S_TXP_S: begin
        PSEL         = 1'b1;
        PADDR        = ADDR_TXDATA;
        w_next_state = S_TXP_A;
      end
      S_TXP_A: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PADDR   = ADDR_TXDATA;
        // TXDATA bit 31 reports a full transmit FIFO: back off and re-arbitrate.
        if (PREADY) w_next_state = PRDATA[31] ? S_IDLE : S_TXW_S;
      end
      S_TXW_S: begin
        PSEL         = 1'b1;
        PWRITE       = 1'b1;
        PADDR        = ADDR_TXDATA;
        PWDATA       = XLEN'(r_mem[r_rd_ptr]);
        PSTRB        = '1;
        w_next_state = S_TXW_A;
      end
      S_TXW_A: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = ADDR_TXDATA;
        PWDATA  = XLEN'(r_mem[r_rd_ptr]);
        PSTRB   = '1;
        if (PREADY) w_next_state = S_IDLE;
      end
`ifdef SPI_FEEDER_RX_EN
      S_RXR_S: begin
        PSEL         = 1'b1;
        PADDR        = ADDR_RXDATA;
        w_next_state = S_RXR_A;
      end
      S_RXR_A: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PADDR   = ADDR_RXDATA;
        if (PREADY) w_next_state = S_IDLE;
      end
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_apb_feeder.sv
// Directed self-checking bench for spi_apb_feeder (DEPTH=16, XLEN=64) with a simple APB slave model.
// RX scenarios run only when SPI_FEEDER_RX_EN is defined.
module tb_spi_apb_feeder;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        TxValid;
  logic [7:0]  TxByte;
  logic        TxReady;
  logic        RxEn;
  logic        RxValid;
  logic [7:0]  RxByte;
  logic        RxReady;
  logic        Busy;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [63:0] PWDATA;
  logic [7:0]  PSTRB;
  logic        PREADY;
  logic [63:0] PRDATA;

  logic [31:0] tx_status;
  logic [31:0] rx_data;

  int checks   = 0;
  int failures = 0;

  int         n_polls    = 0;
  int         n_writes   = 0;
  int         n_rx_reads = 0;
  int         n_setups   = 0;
  logic [7:0] wr_log [64];
  logic [1:0] op_log [64];

  spi_apb_feeder dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .TxValid (TxValid),
    .TxByte  (TxByte),
    .TxReady (TxReady),
    .RxEn    (RxEn),
    .RxValid (RxValid),
    .RxByte  (RxByte),
    .RxReady (RxReady),
    .Busy    (Busy),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA)
  );

  always #5 PCLK = ~PCLK;

  // Slave model: status/data word selected by address; bit 31 = full (TXDATA) or empty (RXDATA).
  assign PRDATA = {32'h0, (PADDR == 8'h4C) ? rx_data : tx_status};

  // Op kinds logged at each setup phase: 0 = TXDATA poll, 1 = TXDATA write, 2 = RXDATA read.
  always @(posedge PCLK) begin
    if (PSEL && !PENABLE) begin
      op_log[n_setups[5:0]] <= PWRITE ? 2'd1 : ((PADDR == 8'h4C) ? 2'd2 : 2'd0);
      n_setups <= n_setups + 1;
    end
    if (PSEL && PENABLE && PREADY) begin
      if (PWRITE) begin
        wr_log[n_writes[5:0]] <= PWDATA[7:0];
        n_writes <= n_writes + 1;
      end else if (PADDR == 8'h48) begin
        n_polls <= n_polls + 1;
      end else begin
        n_rx_reads <= n_rx_reads + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    TxValid = 1'b1;
    TxByte  = b;
    step();
    TxValid = 1'b0;
  endtask

  initial begin
    int         base_w;
    int         base_p;
    int         base_s;
    int         base_r;
    logic [5:0] idx;

    TxValid   = 1'b0;
    TxByte    = 8'h00;
    RxEn      = 1'b0;
    RxReady   = 1'b0;
    PREADY    = 1'b1;
    tx_status = 32'h0;
    rx_data   = 32'h8000_0000;
    PRESETn   = 1'b0;

    #12;
    check("rst_txready", TxReady, 1'b1);
    check("rst_busy", Busy, 1'b0);
    check("rst_psel", PSEL, 1'b0);
    check("rst_pstrb", PSTRB, 8'h00);
    check("rst_pwdata", PWDATA, 64'h0);
    check("rst_rxvalid", RxValid, 1'b0);
    check("rst_rxbyte", RxByte, 8'h00);
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    step();

    // Single byte with PREADY=1: poll, then write, then idle.
    base_w = n_writes;
    base_s = n_setups;
    push(8'hA5);
    check("sb_busy_n", Busy, 1'b1);
    check("sb_psel_n", PSEL, 1'b0);
    step();
    check("sb_ctl_n1", {PSEL, PENABLE, PWRITE}, 3'b100);
    check("sb_addr_n1", PADDR, 8'h48);
    check("sb_strb_n1", PSTRB, 8'h00);
    step();
    check("sb_ctl_n2", {PSEL, PENABLE, PWRITE}, 3'b110);
    step();
    check("sb_ctl_n3", {PSEL, PENABLE, PWRITE}, 3'b101);
    check("sb_wdata_n3", PWDATA, 64'h0000_00A5);
    check("sb_strb_n3", PSTRB, 8'hFF);
    step();
    check("sb_ctl_n4", {PSEL, PENABLE, PWRITE}, 3'b111);
    check("sb_wdata_n4", PWDATA, 64'h0000_00A5);
    step();
    check("sb_busy_n5", Busy, 1'b0);
    check("sb_psel_n5", PSEL, 1'b0);
    check("sb_nwrites", n_writes - base_w, 1);
    idx = 6'(base_w);
    check("sb_wbyte", wr_log[idx], 8'hA5);
    idx = 6'(base_s);
    check("sb_op0", op_log[idx], 2'd0);
    idx = 6'(base_s + 1);
    check("sb_op1", op_log[idx], 2'd1);

    // PREADY stall inside the write access phase.
    base_w = n_writes;
    push(8'h5A);
    step();
    step();
    step();
    PREADY = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      check("stall_ctl", {PSEL, PENABLE, PWRITE}, 3'b111);
      check("stall_addr", PADDR, 8'h48);
      check("stall_wdata", PWDATA, 64'h0000_005A);
      if (k == 3) PREADY = 1'b1;
      step();
    end
    check("stall_psel_done", PSEL, 1'b0);
    check("stall_nwrites", n_writes - base_w, 1);
    idx = 6'(base_w);
    check("stall_wbyte", wr_log[idx], 8'h5A);

    // Slave reports full for three polls, then accepts.
    tx_status = 32'h8000_0000;
    base_w = n_writes;
    base_p = n_polls;
    push(8'h11);
    for (int i = 0; i < 100 && (n_polls - base_p) < 3; i++) step();
    check("full_polls3", n_polls - base_p, 3);
    check("full_nowrite", n_writes - base_w, 0);
    check("full_busy", Busy, 1'b1);
    tx_status = 32'h0;
    for (int i = 0; i < 100 && n_writes == base_w; i++) step();
    check("full_nwrites", n_writes - base_w, 1);
    check("full_polls4", n_polls - base_p, 4);
    idx = 6'(base_w);
    check("full_wbyte", wr_log[idx], 8'h11);
    step();
    step();

    // Fill all 16 entries while the slave is full; pointers start mid-buffer so they wrap.
    tx_status = 32'h8000_0000;
    base_w = n_writes;
    TxValid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      TxByte = 8'(i);
      step();
    end
    TxValid = 1'b0;
    check("wrap_txready_full", TxReady, 1'b0);
    push(8'hEE);
    check("wrap_txready_17", TxReady, 1'b0);
    check("wrap_nowrite", n_writes - base_w, 0);
    tx_status = 32'h0;
    for (int i = 0; i < 400 && (n_writes - base_w) < 16; i++) step();
    check("wrap_nwrites16", n_writes - base_w, 16);
    for (int j = 0; j < 16; j++) begin
      idx = 6'(base_w + j);
      check("wrap_order", wr_log[idx], 8'(j));
    end
    for (int i = 0; i < 10; i++) step();
    check("wrap_no_extra", n_writes - base_w, 16);
    check("wrap_busy", Busy, 1'b0);
    check("wrap_txready", TxReady, 1'b1);

`ifdef SPI_FEEDER_RX_EN
    // Arbitration: RX granted first from IDLE, then alternating with a TX that keeps polling full.
    tx_status = 32'h8000_0000;
    rx_data   = 32'h8000_0000;
    base_s = n_setups;
    base_w = n_writes;
    RxEn = 1'b1;
    push(8'hC3);
    for (int i = 0; i < 30; i++) step();
    for (int k = 0; k < 6; k++) begin
      idx = 6'(base_s + k);
      check("arb_order", op_log[idx], (k % 2 == 0) ? 2'd2 : 2'd0);
    end
    check("arb_rxvalid_empty", RxValid, 1'b0);
    tx_status = 32'h0;
    for (int i = 0; i < 100 && n_writes == base_w; i++) step();
    check("arb_nwrites", n_writes - base_w, 1);
    idx = 6'(base_w);
    check("arb_wbyte", wr_log[idx], 8'hC3);

    // RX capture, hold-off while RxValid, then release and empty reads.
    rx_data = 32'h0000_003C;
    for (int i = 0; i < 50 && !RxValid; i++) step();
    check("rx_valid", RxValid, 1'b1);
    check("rx_byte", RxByte, 8'h3C);
    rx_data = 32'h8000_0000;
    base_r = n_rx_reads;
    for (int i = 0; i < 10; i++) step();
    check("rx_hold_reads", n_rx_reads - base_r, 0);
    check("rx_hold_valid", RxValid, 1'b1);
    RxReady = 1'b1;
    step();
    RxReady = 1'b0;
    check("rx_consumed", RxValid, 1'b0);
    for (int i = 0; i < 10; i++) step();
    check("rx_empty_valid", RxValid, 1'b0);
    check("rx_reads_resume", (n_rx_reads > base_r), 1'b1);
    RxEn = 1'b0;
    for (int i = 0; i < 5; i++) step();
`endif

    // Asynchronous reset during the write access phase; the aborted byte is not replayed.
    base_w = n_writes;
    push(8'h77);
    step();
    step();
    step();
    PREADY = 1'b0;
    step();
    check("rstmid_ctl", {PSEL, PENABLE, PWRITE}, 3'b111);
    #2 PRESETn = 1'b0;
    #1;
    check("rstmid_psel", PSEL, 1'b0);
    check("rstmid_penable", PENABLE, 1'b0);
    PREADY = 1'b1;
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("rstmid_txready", TxReady, 1'b1);
    check("rstmid_busy", Busy, 1'b0);
    check("rstmid_nowrite", n_writes - base_w, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
